// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared defaults and bit-reverse helper for the FFT input buffer
package fft_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int LOG2N_DEF   = 4;
  localparam int MAX_LOG2N   = 10;
  localparam int FRAME_CNT_W = 16;

  // Reverses the low w bits of v; bits at or above w come back as zero.
  function automatic logic [MAX_LOG2N-1:0] bit_rev(input logic [MAX_LOG2N-1:0] v,
                                                    input int w);
    logic [MAX_LOG2N-1:0] r;
    logic [MAX_LOG2N-1:0] t;
    r = '0;
    t = v;
    for (int i = 0; i < MAX_LOG2N; i++) begin
      if (i < w) begin
        r = {r[MAX_LOG2N-2:0], t[0]};
        t = t >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_pp_ram.sv
// rtl/fft_pp_ram.sv - two-bank ping-pong sample RAM, one write port, one registered read port
module fft_pp_ram #(
  parameter int DATA_W = 16,
  parameter int LOG2N  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic              i_wbank,
  input  logic [LOG2N-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_rbank,
  input  logic [LOG2N-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 2 * (1 << LOG2N);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Array contents are deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[{i_wbank, i_waddr}] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[{i_rbank, i_raddr}];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fft_input_buf.sv
// rtl/fft_input_buf.sv - ping-pong frame buffer feeding an FFT core
// Define FFT_IN_BITREV_EN to store each frame in bit-reversed (decimation-in-time) order.
module fft_input_buf
  import fft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LOG2N  = LOG2N_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_i,
  input  logic [DATA_W-1:0]      data_i,
  output logic                   rdy_o,
  output logic                   frame_vld_o,
  input  logic [LOG2N-1:0]       rd_addr_i,
  output logic [DATA_W-1:0]      rd_data_o,
  input  logic                   done_i,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

  localparam int N = 1 << LOG2N;

  logic                   r_wb;
  logic                   r_rb;
  logic [1:0]             r_full;
  logic [LOG2N-1:0]       r_wr_cnt;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;

  logic                   w_accept;
  logic                   w_last;
  logic                   w_release;
  logic [LOG2N-1:0]       w_waddr;
  logic [1:0]             w_full_nxt;

  assign rdy_o       = ~r_full[r_wb];
  assign frame_vld_o = r_full[r_rb];
  assign frame_cnt_o = r_frame_cnt;

  assign w_accept  = req_i & rdy_o;
  assign w_last    = w_accept && (r_wr_cnt == LOG2N'(N - 1));
  assign w_release = done_i & frame_vld_o;

`ifdef FFT_IN_BITREV_EN
  assign w_waddr = LOG2N'(bit_rev(MAX_LOG2N'(r_wr_cnt), LOG2N));
`else
  assign w_waddr = r_wr_cnt;
`endif

  // A release and a frame completion always target different banks, so both apply.
  always_comb begin
    w_full_nxt = r_full;
    if (w_release) begin
      w_full_nxt[r_rb] = 1'b0;
    end
    if (w_last) begin
      w_full_nxt[r_wb] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb        <= 1'b0;
      r_rb        <= 1'b0;
      r_full      <= 2'b00;
      r_wr_cnt    <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_full <= w_full_nxt;
      if (w_release) begin
        r_rb <= ~r_rb;
      end
      if (w_accept) begin
        if (w_last) begin
          r_wb        <= ~r_wb;
          r_wr_cnt    <= '0;
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end else begin
          r_wr_cnt <= r_wr_cnt + 1'b1;
        end
      end
    end
  end

  fft_pp_ram #(
    .DATA_W (DATA_W),
    .LOG2N  (LOG2N)
  ) u_ram (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_we    (w_accept),
    .i_wbank (r_wb),
    .i_waddr (w_waddr),
    .i_wdata (data_i),
    .i_rbank (r_rb),
    .i_raddr (rd_addr_i),
    .o_rdata (rd_data_o)
  );

endmodule

// File: tb/tb_fft_input_buf.sv
// tb/tb_fft_input_buf.sv - directed and random checks of fft_input_buf against a frame-queue model
module tb_fft_input_buf;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_i = 1'b0;
  logic [15:0] data_i = '0;
  logic        done_i = 1'b0;
  logic [3:0]  rd_addr_i = '0;
  logic        rdy_o;
  logic        frame_vld_o;
  logic [15:0] rd_data_o;
  logic [15:0] frame_cnt_o;

  typedef logic [15:0] frame_t [N];

  frame_t      q[$];
  logic [15:0] part[$];
  int          fcnt;
  int          checks = 0;
  int          errors = 0;

`ifdef FFT_IN_BITREV_EN
  localparam logic [15:0] EXP_A1 = 16'd8;
`else
  localparam logic [15:0] EXP_A1 = 16'd1;
`endif

  fft_input_buf #(.DATA_W(16), .LOG2N(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .data_i      (data_i),
    .rdy_o       (rdy_o),
    .frame_vld_o (frame_vld_o),
    .rd_addr_i   (rd_addr_i),
    .rd_data_o   (rd_data_o),
    .done_i      (done_i),
    .frame_cnt_o (frame_cnt_o)
  );

  always #5 clk = ~clk;

  // Which sample index of a frame lives at read address a.
  function automatic int sample_at(input int a);
`ifdef FFT_IN_BITREV_EN
    int r;
    int x;
    r = 0;
    x = a;
    for (int k = 0; k < 4; k++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
`else
    return a;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    req_i  = 1'b0;
    done_i = 1'b0;
    #1;
    q.delete();
    part.delete();
    fcnt = 0;
    chk("rst_rdy", 32'(rdy_o), 32'd1);
    chk("rst_vld", 32'(frame_vld_o), 32'd0);
    chk("rst_cnt", 32'(frame_cnt_o), 32'd0);
    chk("rst_rd_data", 32'(rd_data_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic step(input logic req, input logic [15:0] d, input logic done, input logic [3:0] a);
    bit          acc;
    bit          rel;
    bit          rd_def;
    logic [15:0] exp_rd;
    frame_t      f;
    req_i     = req;
    data_i    = d;
    done_i    = done;
    rd_addr_i = a;
    #1;
    chk("rdy", 32'(rdy_o), 32'(q.size() < 2));
    chk("vld", 32'(frame_vld_o), 32'(q.size() > 0));
    rd_def = q.size() > 0;
    exp_rd = '0;
    if (rd_def) begin
      f      = q[0];
      exp_rd = f[sample_at(int'(a))];
    end
    acc = req && (q.size() < 2);
    rel = done && (q.size() > 0);
    @(posedge clk);
    #1;
    req_i  = 1'b0;
    done_i = 1'b0;
    if (rel) void'(q.pop_front());
    if (acc) begin
      part.push_back(d);
      if (part.size() == N) begin
        for (int i = 0; i < N; i++) f[i] = part[i];
        q.push_back(f);
        part.delete();
        fcnt++;
      end
    end
    chk("frame_cnt", 32'(frame_cnt_o), 32'(fcnt & 16'hffff));
    if (rd_def) chk("rd_data", 32'(rd_data_o), 32'(exp_rd));
  endtask

  initial begin
    // Natural-order frame 0..15, then read address 1.
    do_reset();
    for (int i = 0; i < N; i++) step(1'b1, 16'(i), 1'b0, 4'd0);
    chk("first_vld", 32'(frame_vld_o), 32'd1);
    chk("first_cnt", 32'(frame_cnt_o), 32'd1);
    step(1'b0, 16'h0, 1'b0, 4'd1);
    chk("first_a1", 32'(rd_data_o), 32'(EXP_A1));

    // Both banks filled, overflow sample held, then released.
    do_reset();
    for (int i = 0; i < 2 * N; i++) step(1'b1, 16'h7fff, 1'b0, 4'd0);
    chk("full_rdy", 32'(rdy_o), 32'd0);
    step(1'b1, 16'h0000, 1'b0, 4'd0);
    chk("full_cnt", 32'(frame_cnt_o), 32'd2);
    chk("full_vld", 32'(frame_vld_o), 32'd1);
    step(1'b1, 16'h0000, 1'b1, 4'd0);
    chk("rel_rdy", 32'(rdy_o), 32'd1);
    chk("rel_vld", 32'(frame_vld_o), 32'd1);
    step(1'b1, 16'h0000, 1'b0, 4'd0);
    chk("rel_rd", 32'(rd_data_o), 32'h7fff);

    // Final write into bank 1 coincides with release of bank 0.
    do_reset();
    for (int i = 0; i < N + N - 1; i++) step(1'b1, 16'($urandom), 1'b0, 4'($urandom));
    step(1'b1, 16'h1234, 1'b1, 4'd0);
    chk("coin_vld", 32'(frame_vld_o), 32'd1);
    chk("coin_rdy", 32'(rdy_o), 32'd1);
    chk("coin_cnt", 32'(frame_cnt_o), 32'd2);
    for (int i = 0; i < N; i++) step(1'b0, 16'h0, 1'b0, 4'(i));

    // Reset mid-frame, stray done, then a full frame.
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 16'($urandom), 1'b0, 4'd0);
    do_reset();
    step(1'b0, 16'h0, 1'b1, 4'd0);
    chk("stray_done_cnt", 32'(frame_cnt_o), 32'd0);
    for (int i = 0; i < N - 1; i++) step(1'b1, 16'($urandom), 1'b0, 4'd0);
    chk("pre_last_vld", 32'(frame_vld_o), 32'd0);
    step(1'b1, 16'hbeef, 1'b0, 4'd0);
    chk("post_last_vld", 32'(frame_vld_o), 32'd1);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 3) != 0), 16'($urandom),
             1'($urandom_range(0, 4) == 0), 4'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
